// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//   Memory-mapped 4-digit 7-segment scan controller. Software writes a 16-bit
//   hex VALUE (double-buffered, shadow -> active at frame boundaries) and a
//   CTRL word; the block multiplexes the digits with a blanking gap at the
//   start of every digit slot.
//
//   Optional feature: define SEG7_DIMMING_EN to enable PWM dimming of the
//   SHOW phase via CTRL[15:12] (DUTY). When undefined, DUTY is stored and
//   read back only.
//
// Ports
//   clk        system clock
//   reset      synchronous active-low reset
//   wr_en      register write strobe (one cycle)
//   wr_sel     write target: 0 = VALUE shadow, 1 = CTRL
//   wr_data    write data, bits [15:0] used
//   rd_sel     read target: 0 = VALUE shadow, 1 = CTRL
//   rd_data    combinational readback {16'b0, selected register}
//   frame_tick one-cycle pulse in the last cycle of the digit-3 slot
//   BCD7       [11:8] anodes digit 3..0, [7:0] segments {dp,g..a}, active-low
//
// CTRL: [0] EN, [1] LZB, [7:4] DP per digit, [11:8] digit mask, [15:12] DUTY
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [31:0] wr_data,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        frame_tick,
  output logic [11:0] BCD7
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
`ifdef SEG7_DIMMING_EN
  localparam int unsigned SUB_LEN = (REFRESH_DIV - BLANK_CYCLES) / 16;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       digit, digit_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [15:0] value_shadow;
  logic [15:0] value_active;
  logic [15:0] ctrl;

  logic        copy_c;
  logic [11:0] bcd_nxt;
  logic        tick_nxt;

  logic        ctrl_en;
  logic        ctrl_lzb;
  logic [3:0]  ctrl_dp;
  logic [3:0]  ctrl_mask;

  assign ctrl_en   = ctrl[0];
  assign ctrl_lzb  = ctrl[1];
  assign ctrl_dp   = ctrl[7:4];
  assign ctrl_mask = ctrl[11:8];

  // Upper write-data bits are architecturally ignored.
  logic unused_wr_hi;
  assign unused_wr_hi = ^wr_data[31:16];

  // Readback is combinational and reflects the shadow, not the displayed value.
  assign rd_data = {16'b0, (rd_sel ? ctrl : value_shadow)};

  // Hex nibble to active-low segments {g,f,e,d,c,b,a} with dp (bit 7) off.
  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Next-state logic: slot counter runs 0..REFRESH_DIV-1 across BLANK and SHOW.
  always_comb begin
    state_nxt = state;
    digit_nxt = digit;
    cnt_nxt   = cnt;
    if (!ctrl_en) begin
      state_nxt = ST_IDLE;
      digit_nxt = 2'd0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_BLANK;
          digit_nxt = 2'd0;
          cnt_nxt   = '0;
        end
        ST_BLANK: begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == BLANK_LAST) state_nxt = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt == SLOT_LAST) begin
            state_nxt = ST_BLANK;
            digit_nxt = digit + 2'd1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          digit_nxt = 2'd0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Shadow -> active copy: continuously while idle, and on entry to a new frame.
  assign copy_c = (state == ST_IDLE) ||
                  ((state == ST_SHOW) && (state_nxt == ST_BLANK) && (digit_nxt == 2'd0));

  // Registered display outputs are computed from the upcoming state.
  always_comb begin
    logic [3:0] nib;
    logic [7:0] seg;
    logic       lz;
    logic       lit;
    bcd_nxt  = 12'hFFF;
    tick_nxt = 1'b0;
    nib      = value_active[{digit_nxt, 2'b00} +: 4];
    seg      = hex_seg(nib);
    lz       = 1'b0;
    lit      = 1'b0;

    // A digit is a leading zero when it and every higher nibble are zero.
    case (digit_nxt)
      2'd1:    lz = (value_active[15:4]  == 12'h000);
      2'd2:    lz = (value_active[15:8]  == 8'h00);
      2'd3:    lz = (value_active[15:12] == 4'h0);
      default: lz = 1'b0;
    endcase

    lit = ctrl_mask[digit_nxt] && !(ctrl_lzb && lz);
`ifdef SEG7_DIMMING_EN
    lit = lit && ((32'(cnt_nxt) - 32'(BLANK_CYCLES)) <
                  (32'(SUB_LEN) * (32'(ctrl[15:12]) + 32'd1)));
`endif

    if (ctrl_dp[digit_nxt]) seg[7] = 1'b0;

    if ((state_nxt == ST_SHOW) && lit) begin
      bcd_nxt = {~(4'b0001 << digit_nxt), seg};
    end

    tick_nxt = (state_nxt == ST_SHOW) && (digit_nxt == 2'd3) && (cnt_nxt == SLOT_LAST);
  end

  // State, registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      digit        <= 2'd0;
      cnt          <= '0;
      value_shadow <= 16'h0000;
      value_active <= 16'h0000;
      ctrl         <= 16'h0000;
      BCD7         <= 12'hFFF;
      frame_tick   <= 1'b0;
    end else begin
      state      <= state_nxt;
      digit      <= digit_nxt;
      cnt        <= cnt_nxt;
      BCD7       <= bcd_nxt;
      frame_tick <= tick_nxt;
      if (wr_en && !wr_sel) value_shadow <= wr_data[15:0];
      if (wr_en &&  wr_sel) ctrl         <= wr_data[15:0];
      // Copy uses the pre-edge shadow, so a same-edge write waits a frame.
      if (copy_c) value_active <= value_shadow;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Self-checking bench for seg7_scan_driver. Expected BCD7/frame_tick values
//   per cycle are generated by a small frame model and queued as stimulus is
//   driven; each cycle the head of the queue is compared with the DUT.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

`ifdef SEG7_DIMMING_EN
  localparam int R = 34;
`else
  localparam int R = 8;
`endif
  localparam int B = 2;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic        wr_sel;
  logic [31:0] wr_data;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        frame_tick;
  logic [11:0] BCD7;

  typedef struct packed {
    logic [11:0] bcd;
    logic        tick;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg7_scan_driver #(
    .REFRESH_DIV (R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .frame_tick(frame_tick),
    .BCD7      (BCD7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output for cycle 'cyc' of an enabled frame (cycle 0 = digit-0 BLANK start).
  function automatic exp_t model(input int cyc, input logic [15:0] v, input logic [15:0] c);
    exp_t       e;
    int         k;
    int         cnt;
    logic [15:0] sh;
    logic [3:0] mask;
    logic [7:0] seg;
    logic       lit;
    k      = cyc / R;
    cnt    = cyc % R;
    sh     = v >> (4 * k);
    mask   = c[11:8];
    e.tick = (cyc == 4 * R - 1);
    e.bcd  = 12'hFFF;
    lit    = (cnt >= B) && mask[k] && !(c[1] && (k != 0) && (sh == 16'h0000));
`ifdef SEG7_DIMMING_EN
    if ((cnt - B) >= ((R - B) / 16) * (int'(c[15:12]) + 1)) lit = 1'b0;
`endif
    if (lit) begin
      seg = seg_tbl[sh[3:0]];
      if (c[4 + k]) seg[7] = 1'b0;
      e.bcd = {~(4'b0001 << k), seg};
    end
    return e;
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic [15:0] c, input int ncyc);
    for (int i = 0; i < ncyc; i++) sb.push_back(model(i, v, c));
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    e.bcd  = 12'hFFF;
    e.tick = 1'b0;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    wr_data = '0;
    rd_sel  = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (BCD7 !== 12'hFFF || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: BCD7=%h tick=%b, expected BCD7=fff tick=0", BCD7, frame_tick);
    end
    rd_sel = 1'b0; #1;
    n_checks++;
    if (rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rd_value: rd_data=%h, expected 00000000", rd_data);
    end
    rd_sel = 1'b1; #1;
    n_checks++;
    if (rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rd_ctrl: rd_data=%h, expected 00000000", rd_data);
    end
    rd_sel = 1'b0;
    reset  = 1'b1;
  endtask

  task automatic test_scan();
    exp_t e;
    @(negedge clk);
    wr_en = 1'b1; wr_sel = 1'b0; wr_data = 32'hFFFF_1234;
    @(negedge clk);
    wr_sel = 1'b1; wr_data = 32'h0000_0F01;
    @(negedge clk);
    wr_en = 1'b0;
    rd_sel = 1'b0; #1;
    n_checks++;
    if (rd_data !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL scan_rd_value: rd_data=%h, expected 00001234", rd_data);
    end
    push_frame(16'h1234, 16'h0F01, 4 * R);
    push_frame(16'h1234, 16'h0F01, 4 * R);
    for (int i = 0; i < 8 * R; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (BCD7 !== e.bcd || frame_tick !== e.tick) begin
        n_fail++;
        $display("FAIL scan cyc %0d: BCD7=%h tick=%b, expected BCD7=%h tick=%b",
                 i, BCD7, frame_tick, e.bcd, e.tick);
      end
    end
  endtask

  task automatic test_midframe_write();
    exp_t e;
    push_frame(16'h1234, 16'h0F01, 4 * R);
    push_frame(16'hABCD, 16'h0F01, 4 * R);
    for (int i = 0; i < 8 * R; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (BCD7 !== e.bcd || frame_tick !== e.tick) begin
        n_fail++;
        $display("FAIL midframe cyc %0d: BCD7=%h tick=%b, expected BCD7=%h tick=%b",
                 i, BCD7, frame_tick, e.bcd, e.tick);
      end
      if (i == 2 * R + B + 1) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_data = 32'h0000_ABCD;
      end
      if (i == 2 * R + B + 2) wr_en = 1'b0;
    end
  endtask

  // VALUE write lands on the frame-boundary edge, so it waits one more frame.
  task automatic test_lzb_dp_boundary();
    exp_t e;
    wr_en = 1'b1; wr_sel = 1'b0; wr_data = 32'h0000_0005;
    push_frame(16'hABCD, 16'h0F13, 4 * R);
    push_frame(16'h0005, 16'h0F13, 4 * R);
    for (int i = 0; i < 8 * R; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (BCD7 !== e.bcd || frame_tick !== e.tick) begin
        n_fail++;
        $display("FAIL lzb_dp cyc %0d: BCD7=%h tick=%b, expected BCD7=%h tick=%b",
                 i, BCD7, frame_tick, e.bcd, e.tick);
      end
      if (i == 0) begin
        wr_sel = 1'b1; wr_data = 32'h0000_0F13;
      end
      if (i == 1) wr_en = 1'b0;
    end
  endtask

  task automatic test_en_clear();
    exp_t e;
    push_frame(16'h0005, 16'h0F13, B + 3);
    push_idle(6);
    push_frame(16'h0005, 16'h0F13, 4 * R);
    for (int i = 0; i < B + 9 + 4 * R; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (BCD7 !== e.bcd || frame_tick !== e.tick) begin
        n_fail++;
        $display("FAIL en_clear cyc %0d: BCD7=%h tick=%b, expected BCD7=%h tick=%b",
                 i, BCD7, frame_tick, e.bcd, e.tick);
      end
      if (i == B + 1) begin
        wr_en = 1'b1; wr_sel = 1'b1; wr_data = 32'h0000_0F12;
      end
      if (i == B + 2) wr_en = 1'b0;
      if (i == B + 5) begin
        rd_sel = 1'b1; #1;
        n_checks++;
        if (rd_data !== 32'h0000_0F12) begin
          n_fail++;
          $display("FAIL en_clear_rd_ctrl: rd_data=%h, expected 00000f12", rd_data);
        end
        rd_sel = 1'b0; #1;
        n_checks++;
        if (rd_data !== 32'h0000_0005) begin
          n_fail++;
          $display("FAIL en_clear_rd_value: rd_data=%h, expected 00000005", rd_data);
        end
      end
      if (i == B + 7) begin
        wr_en = 1'b1; wr_sel = 1'b1; wr_data = 32'h0000_0F13;
      end
      if (i == B + 8) wr_en = 1'b0;
    end
  endtask

  task automatic test_reset_midframe(input logic [15:0] v, input logic [15:0] c);
    exp_t e;
    push_frame(v, c, B + 2);
    for (int i = 0; i < B + 2; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (BCD7 !== e.bcd || frame_tick !== e.tick) begin
        n_fail++;
        $display("FAIL pre_reset cyc %0d: BCD7=%h tick=%b, expected BCD7=%h tick=%b",
                 i, BCD7, frame_tick, e.bcd, e.tick);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rd_sel = 1'b1; #1;
    n_checks++;
    if (rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_rd_ctrl: rd_data=%h, expected 00000000", rd_data);
    end
    rd_sel = 1'b0; #1;
    n_checks++;
    if (rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_rd_value: rd_data=%h, expected 00000000", rd_data);
    end
    push_idle(1 + 4);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (BCD7 !== e.bcd || frame_tick !== e.tick) begin
        n_fail++;
        $display("FAIL midreset cyc %0d: BCD7=%h tick=%b, expected BCD7=%h tick=%b",
                 i, BCD7, frame_tick, e.bcd, e.tick);
      end
    end
  endtask

`ifdef SEG7_DIMMING_EN
  task automatic test_dimming();
    exp_t e;
    @(negedge clk);
    wr_en = 1'b1; wr_sel = 1'b0; wr_data = 32'h0000_1234;
    @(negedge clk);
    wr_sel = 1'b1; wr_data = 32'h0000_3F01;
    @(negedge clk);
    wr_en = 1'b0;
    push_frame(16'h1234, 16'h3F01, 4 * R);
    for (int i = 0; i < 4 * R; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (BCD7 !== e.bcd || frame_tick !== e.tick) begin
        n_fail++;
        $display("FAIL dimming cyc %0d: BCD7=%h tick=%b, expected BCD7=%h tick=%b",
                 i, BCD7, frame_tick, e.bcd, e.tick);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_midframe_write();
    test_lzb_dp_boundary();
    test_en_clear();
    test_reset_midframe(16'h0005, 16'h0F13);
`ifdef SEG7_DIMMING_EN
    test_dimming();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
